// File: rtl/eth_mac_pkg.sv
// Shared types and constants for the MII transmit arbiter.
// Arbiter state encoding, TransmitStatus bit positions, counter width.
package eth_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_WAIT_STATUS,
    ST_WAIT_LAST
  } arb_state_t;

  localparam int TX_STAT_OK       = 0;
  localparam int TX_STAT_GAVE_UP  = 1;
  localparam int TX_STAT_LATE     = 2;
  localparam int TX_STAT_UNDERFLOW = 3;

  localparam int STAT_CNT_W = 16;

  function automatic logic [STAT_CNT_W-1:0] sat_inc(
    input logic [STAT_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request after ptr.
// Searches ptr+1 .. ptr+PORTS modulo PORTS.
module rr_pick #(
  parameter int PORTS = 2,
  parameter int PW    = 3
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    win,
  output logic             any
);

  int idx;

  always_comb begin
    win = '0;
    idx = 0;
    // walk backwards so the nearest requester is written last
    for (int k = PORTS; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (req[idx]) win = PW'(idx);
    end
    any = |req;
  end

endmodule

// File: rtl/axis_mii_tx_arbiter.sv
// Frame-level round-robin arbiter in front of a half-duplex MII TX MAC.
// Optional per-port counters: define AXIS_MII_TX_ARBITER_STATS_EN.
module axis_mii_tx_arbiter
  import eth_mac_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int PW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*8-1:0] s_axis_data,
  input  logic [PORTS-1:0]   s_axis_valid,
  output logic [PORTS-1:0]   s_axis_ready,
  input  logic [PORTS-1:0]   s_axis_last,
  input  logic [PORTS-1:0]   s_axis_err,
  output logic [7:0]         m_axis_data,
  output logic               m_axis_valid,
  input  logic               m_axis_ready,
  output logic               m_axis_last,
  output logic               m_axis_err,
  input  logic               transmit_ok,
  input  logic               gave_up,
  input  logic               late_collision,
  input  logic               underflow,
  output logic [PORTS-1:0]   grant,
  output logic               status_valid,
  output logic [PW-1:0]      status_port,
  output logic [3:0]         status_code
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [PORTS*STAT_CNT_W-1:0]   stat_ok,
  output logic [PORTS*STAT_CNT_W-1:0]   stat_fail
`endif
);

  arb_state_t state, state_n;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          any;
  logic [3:0]    acc;
  logic [3:0]    st_in;
  logic [3:0]    acc_n;
  logic          pass;
  logic          beat;
  logic          emit;

  rr_pick #(
    .PORTS(PORTS),
    .PW   (PW)
  ) u_pick (
    .req(s_axis_valid),
    .ptr(ptr),
    .win(win),
    .any(any)
  );

  always_comb begin
    st_in = '0;
    st_in[TX_STAT_OK]        = transmit_ok;
    st_in[TX_STAT_GAVE_UP]   = gave_up;
    st_in[TX_STAT_LATE]      = late_collision;
    st_in[TX_STAT_UNDERFLOW] = underflow;
  end

  assign acc_n = acc | st_in;
  assign pass  = (state == ST_FRAME) || (state == ST_WAIT_LAST);

  always_comb begin
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    m_axis_err   = 1'b0;
    s_axis_ready = '0;
    if (pass) begin
      for (int i = 0; i < PORTS; i++) begin
        if (ptr == PW'(i)) begin
          m_axis_data     = s_axis_data[i*8 +: 8];
          m_axis_valid    = s_axis_valid[i];
          m_axis_last     = s_axis_last[i];
          m_axis_err      = s_axis_err[i];
          s_axis_ready[i] = m_axis_ready;
        end
      end
    end
  end

  assign beat = m_axis_valid & m_axis_ready & m_axis_last;

  always_comb begin
    state_n = state;
    emit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any) state_n = ST_FRAME;
      end
      ST_FRAME: begin
        if (beat) begin
          if (|acc_n) emit = 1'b1;
          else state_n = ST_WAIT_STATUS;
        end else if (|st_in) begin
          state_n = ST_WAIT_LAST;
        end
      end
      ST_WAIT_STATUS: begin
        if (|st_in) emit = 1'b1;
      end
      ST_WAIT_LAST: begin
        if (beat) emit = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (emit) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= PW'(PORTS-1);
      acc          <= '0;
      grant        <= '0;
      status_valid <= 1'b0;
      status_port  <= '0;
      status_code  <= '0;
    end else begin
      state        <= state_n;
      status_valid <= emit;
      if (state == ST_IDLE) begin
        if (any) begin
          ptr   <= win;
          grant <= {{(PORTS-1){1'b0}}, 1'b1} << win;
          acc   <= '0;
        end
      end else begin
        acc <= acc_n;
      end
      if (emit) begin
        status_port <= ptr;
        status_code <= acc_n;
        grant       <= '0;
      end
    end
  end

`ifdef AXIS_MII_TX_ARBITER_STATS_EN
  logic emit_ok;

  assign emit_ok = (acc_n == 4'b0001);

  for (genvar g = 0; g < PORTS; g++) begin : g_stat
    logic [STAT_CNT_W-1:0] ok_cnt;
    logic [STAT_CNT_W-1:0] fail_cnt;

    always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
        ok_cnt   <= '0;
        fail_cnt <= '0;
      end else if (emit && (ptr == PW'(g))) begin
        if (emit_ok) ok_cnt <= sat_inc(ok_cnt);
        else fail_cnt <= sat_inc(fail_cnt);
      end
    end

    assign stat_ok[g*STAT_CNT_W +: STAT_CNT_W]   = ok_cnt;
    assign stat_fail[g*STAT_CNT_W +: STAT_CNT_W] = fail_cnt;
  end
`endif

endmodule

// File: tb/tb_axis_mii_tx_arbiter.sv
// Randomized bench for axis_mii_tx_arbiter against a frame-level model.
// Model tracks owner, last-beat and status flags per granted frame.
module tb_axis_mii_tx_arbiter;
  import eth_mac_pkg::*;

  localparam int PORTS = 2;
  localparam int PW    = 3;
  localparam int CYC   = 20000;

  logic               clk = 1'b0;
  logic               rst;
  logic [PORTS*8-1:0] s_axis_data;
  logic [PORTS-1:0]   s_axis_valid;
  logic [PORTS-1:0]   s_axis_ready;
  logic [PORTS-1:0]   s_axis_last;
  logic [PORTS-1:0]   s_axis_err;
  logic [7:0]         m_axis_data;
  logic               m_axis_valid;
  logic               m_axis_ready;
  logic               m_axis_last;
  logic               m_axis_err;
  logic               transmit_ok;
  logic               gave_up;
  logic               late_collision;
  logic               underflow;
  logic [PORTS-1:0]   grant;
  logic               status_valid;
  logic [PW-1:0]      status_port;
  logic [3:0]         status_code;
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
  logic                        stat_clear;
  logic [PORTS*STAT_CNT_W-1:0] stat_ok;
  logic [PORTS*STAT_CNT_W-1:0] stat_fail;
  int                          m_ok [PORTS];
  int                          m_fail [PORTS];
`endif

  always #5 clk = ~clk;

  axis_mii_tx_arbiter #(
    .PORTS(PORTS),
    .PW   (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_data   (s_axis_data),
    .s_axis_valid  (s_axis_valid),
    .s_axis_ready  (s_axis_ready),
    .s_axis_last   (s_axis_last),
    .s_axis_err    (s_axis_err),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .m_axis_last   (m_axis_last),
    .m_axis_err    (m_axis_err),
    .transmit_ok   (transmit_ok),
    .gave_up       (gave_up),
    .late_collision(late_collision),
    .underflow     (underflow),
    .grant         (grant),
    .status_valid  (status_valid),
    .status_port   (status_port),
    .status_code   (status_code)
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_ok       (stat_ok),
    .stat_fail     (stat_fail)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [PORTS-1:0] req,
                                 input int last);
    for (int k = 1; k <= PORTS; k++) begin
      if (req[(last + k) % PORTS]) return (last + k) % PORTS;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rand_code();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 4'b0001;
    if (r == 6) return 4'b0010;
    if (r == 7) return 4'b0100;
    if (r == 8) return 4'b1000;
    return 4'($urandom_range(1, 15));
  endfunction

  // source frames
  logic [7:0] fdata [PORTS][32];
  int         flen [PORTS];
  int         fidx [PORTS];
  bit         fact [PORTS];
  bit         ferr [PORTS];
  int         fgap [PORTS];

  // arbiter model
  int               owner;
  int               last_win;
  bit               got_last;
  bit               got_st;
  logic [3:0]       acc;
  logic [PORTS-1:0] exp_grant;
  bit               exp_sv;
  int               exp_port;
  logic [3:0]       exp_code;
  int               n_emit;
  int               n_under;
  bit               rst_done;
  bit               acc_beat;
  bit               acc_last;
  logic [3:0]       st;
  logic [PORTS-1:0] one;

  initial begin
    rst = 1'b1;
    s_axis_data = '0;
    s_axis_valid = '0;
    s_axis_last = '0;
    s_axis_err = '0;
    m_axis_ready = 1'b0;
    {underflow, late_collision, gave_up, transmit_ok} = 4'b0;
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
    stat_clear = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      m_ok[p] = 0;
      m_fail[p] = 0;
    end
`endif
    for (int p = 0; p < PORTS; p++) begin
      fact[p] = 1'b0;
      fgap[p] = 0;
      fidx[p] = 0;
      flen[p] = 1;
      ferr[p] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sv", 32'(status_valid), 32'h0);
    chk("rst_port", 32'(status_port), 32'h0);
    chk("rst_code", 32'(status_code), 32'h0);
    chk("rst_mvalid", 32'(m_axis_valid), 32'h0);
    chk("rst_sready", 32'(s_axis_ready), 32'h0);
    rst = 1'b0;
    owner = -1;
    last_win = PORTS - 1;
    got_last = 1'b0;
    got_st = 1'b0;
    acc = '0;
    exp_grant = '0;
    exp_sv = 1'b0;
    exp_port = 0;
    exp_code = '0;
    n_emit = 0;
    n_under = 0;
    rst_done = 1'b0;

    for (int cyc = 0; cyc < CYC; cyc++) begin
      @(negedge clk);
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("status_valid", 32'(status_valid), 32'(exp_sv));
      if (exp_sv) begin
        chk("status_port", 32'(status_port), 32'(exp_port));
        chk("status_code", 32'(status_code), 32'(exp_code));
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
        chk("stat_ok", 32'(stat_ok[exp_port*16 +: 16]), 32'(m_ok[exp_port]));
        chk("stat_fail", 32'(stat_fail[exp_port*16 +: 16]),
            32'(m_fail[exp_port]));
`endif
      end

      for (int p = 0; p < PORTS; p++) begin
        if (!fact[p]) begin
          if (fgap[p] > 0) fgap[p]--;
          else begin
            flen[p] = int'($urandom_range(1, 20));
            for (int b = 0; b < 32; b++) fdata[p][b] = 8'($urandom);
            fidx[p] = 0;
            ferr[p] = ($urandom_range(0, 7) == 0);
            fact[p] = 1'b1;
          end
        end
        s_axis_valid[p] = fact[p] && ($urandom_range(0, 4) != 0);
        s_axis_data[p*8 +: 8] = fact[p] ? fdata[p][fidx[p]] : 8'($urandom);
        s_axis_last[p] = fact[p] && (fidx[p] == flen[p] - 1);
        s_axis_err[p] = fact[p] && ferr[p] && (fidx[p] == flen[p] - 1);
      end
      m_axis_ready = ($urandom_range(0, 3) != 0);
      rst = (!rst_done && cyc > 2000 && owner >= 0 && !got_last &&
             fidx[owner] >= 3);
      #1;

      if (owner < 0) begin
        chk("idle_mvalid", 32'(m_axis_valid), 32'h0);
        chk("idle_sready", 32'(s_axis_ready), 32'h0);
      end else begin
        one = '0;
        one[owner] = 1'b1;
        if (!got_last) begin
          chk("m_valid", 32'(m_axis_valid), 32'(s_axis_valid[owner]));
          chk("s_ready", 32'(s_axis_ready), m_axis_ready ? 32'(one) : 32'h0);
          if (s_axis_valid[owner]) begin
            chk("m_data", 32'(m_axis_data), 32'(fdata[owner][fidx[owner]]));
            chk("m_last", 32'(m_axis_last),
                32'(fidx[owner] == flen[owner] - 1));
            chk("m_err", 32'(m_axis_err), 32'(s_axis_err[owner]));
          end
        end else begin
          chk("isolate", 32'(s_axis_ready & ~one), 32'h0);
        end
      end

      acc_beat = (owner >= 0) && !got_last && s_axis_valid[owner] &&
                 m_axis_ready;
      acc_last = acc_beat && (fidx[owner] == flen[owner] - 1);

      st = '0;
      if (owner < 0) begin
        if ($urandom_range(0, 19) == 0) st = rand_code();
      end else if (!got_st) begin
        if (got_last) begin
          if ($urandom_range(0, 2) == 0) st = rand_code();
        end else if (acc_last) begin
          if ($urandom_range(0, 3) == 0) st = rand_code();
        end else if ($urandom_range(0, 39) == 0) begin
          st = 4'b1000;
        end
      end else if (!got_last && $urandom_range(0, 29) == 0) begin
        st = rand_code();
      end
      {underflow, late_collision, gave_up, transmit_ok} = st;

      exp_sv = 1'b0;
      if (rst) begin
        rst_done = 1'b1;
        owner = -1;
        last_win = PORTS - 1;
        got_last = 1'b0;
        got_st = 1'b0;
        exp_grant = '0;
        for (int p = 0; p < PORTS; p++) begin
          fact[p] = 1'b0;
          fgap[p] = 0;
        end
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
        for (int p = 0; p < PORTS; p++) begin
          m_ok[p] = 0;
          m_fail[p] = 0;
        end
`endif
      end else if (owner < 0) begin
        if (|s_axis_valid) begin
          owner = rr_next(s_axis_valid, last_win);
          last_win = owner;
          got_last = 1'b0;
          got_st = 1'b0;
          acc = '0;
          exp_grant = '0;
          exp_grant[owner] = 1'b1;
        end
      end else begin
        if (acc_beat) begin
          if (acc_last) begin
            got_last = 1'b1;
            fact[owner] = 1'b0;
            fgap[owner] = int'($urandom_range(0, 3));
          end else begin
            fidx[owner]++;
          end
        end
        if (|st && !got_st && !got_last) n_under++;
        acc = acc | st;
        if (|st) got_st = 1'b1;
        if (got_last && got_st) begin
          exp_sv = 1'b1;
          exp_port = owner;
          exp_code = acc;
          n_emit++;
`ifdef AXIS_MII_TX_ARBITER_STATS_EN
          if (acc == 4'b0001) begin
            if (m_ok[owner] < 65535) m_ok[owner]++;
          end else if (m_fail[owner] < 65535) begin
            m_fail[owner]++;
          end
`endif
          owner = -1;
          exp_grant = '0;
        end
      end
    end

    chk("frames_seen", 32'(n_emit > 100), 32'h1);
    chk("early_status_seen", 32'(n_under > 0), 32'h1);
    chk("reset_hit", 32'(rst_done), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
